armleo_stream_packer: RTL
=========================

// Module: armleo_stream_packer
// PURPOSE
//  Width upsizer for valid/ready/data streams. Packs RATIO narrow DW-bit beats
//  into one DW*RATIO-bit word, lane 0 first (little-endian lane order).
//  Sits directly upstream of armleo_register_slice (out_* feeds the slice's in_*),
//  which decouples the combinational out_ready->in_ready path below.
//  in_last closes a partial word early; out_keep marks the valid lanes.
// PARAMETERS
//  DW     8  bits per input beat / per output lane
//  RATIO  4  input beats per output word; legal range RATIO>=2
// PORTS
//  clk        in   1         clock, all state on posedge
//  rst_n      in   1         reset, synchronous, active-low
//  in_valid   in   1         input beat valid
//  in_data    in   DW        input beat data
//  in_last    in   1         beat is last of packet, closes current word
//  in_ready   out  1         input beat accepted when in_valid && in_ready
//  out_valid  out  1         packed word valid
//  out_data   out  DW*RATIO  packed word; lane k = out_data[k*DW +: DW]
//  out_keep   out  RATIO     per-lane valid, contiguous from lane 0
//  out_last   out  1         word closed by in_last
//  out_ready  in   1         word accepted when out_valid && out_ready
// BEHAVIOUR
//  State: acc_data[DW*RATIO], acc_keep[RATIO], cnt[$clog2(RATIO)] (next lane),
//   output register out_data/out_keep/out_last/out_valid.
//  rst_n=0 at posedge: out_valid=0, out_data=0, out_keep=0, out_last=0, cnt=0,
//   acc_data=0, acc_keep=0. A partial word in progress is discarded.
//  in_ready = !out_valid || out_ready (combinational; independent of in_valid,
//   in_last and cnt). Forced 0 while rst_n=0.
//  Accepted beat, not completing (cnt<RATIO-1 and !in_last):
//   acc lane[cnt]<=in_data, acc_keep[cnt]<=1, cnt<=cnt+1.
//  Completing beat (cnt==RATIO-1 or in_last): output register loads
//   acc merged with in_data in lane cnt; out_keep=acc_keep|(1<<cnt);
//   out_last=in_last; out_valid<=1. acc_data, acc_keep, cnt cleared to 0.
//   Lanes above cnt are 0 in out_data and out_keep.
//  Latency: out_valid rises the cycle after the completing beat's handshake.
//  Output handshake with no completing beat that cycle: out_valid<=0; out_data,
//   out_keep, out_last hold.
//  Simultaneous output handshake and completing beat: new word loaded,
//   out_valid stays 1; full throughput, no bubble.
//  out_valid && !out_ready: out_* held stable, in_ready=0, acc untouched.
//  in_last at cnt==RATIO-1: single full word, out_last=1, keep all ones.
//  in_last at cnt==0: single-lane word, out_keep=1.
//  cnt wraps RATIO-1 -> 0; never exceeds RATIO-1.
//  in_data/in_last ignored without handshake.
// TESTING (DW=8, RATIO=4)
//  1. Beats 11,22,33,44, no last, out_ready=1 -> next cycle out_valid=1,
//     out_data=32'h44332211, out_keep=4'b1111, out_last=0, for one cycle.
//  2. Beats A1, A2(last) -> out_data=32'h0000A2A1, out_keep=4'b0011, out_last=1;
//     following beat 55 (last) -> out_data=32'h00000055, out_keep=4'b0001.
//  3. out_ready=0 after word completes -> in_ready=0, out_* stable 5 cycles;
//     raise out_ready -> word taken, in_ready=1 same cycle, next word packs.
//  4. 8 back-to-back beats 01..08, out_ready=1 -> in_ready never drops;
//     words 32'h04030201, 32'h08070605 on consecutive completions.
//  5. rst_n=0 for 1 cycle after beats 11,22 -> all outputs 0; then 31..34 ->
//     out_data=32'h34333231, keep 4'b1111 (no stale lanes).
//  6. Random valid/ready stalls, 1000 beats, random in_last -> scoreboard
//     matches reference packing; out_* stable while out_valid && !out_ready.

Source files
------------

// File: rtl/armleo_stream_packer.sv
// ---------------------------------------------------------------------------
// armleo_stream_packer
//
// Width upsizer for valid/ready/data streams. Collects up to RATIO narrow
// DW-bit beats into one DW*RATIO-bit word, lane 0 first (little-endian lane
// order). A beat with in_last closes the current word early; out_keep then
// marks the lanes that carry data, always contiguous from lane 0.
//
// The output side is a single register stage. in_ready is a combinational
// function of out_valid/out_ready, so this block is meant to sit directly
// upstream of armleo_register_slice, which breaks that path.
//
// Parameters
//   DW     bits per input beat / per output lane
//   RATIO  input beats per output word (RATIO >= 2)
//
// Ports
//   clk        in   1         clock, all state updates on posedge
//   rst_n      in   1         synchronous active-low reset
//   in_valid   in   1         input beat valid
//   in_data    in   DW        input beat data
//   in_last    in   1         last beat of packet, closes the current word
//   in_ready   out  1         beat accepted when in_valid && in_ready
//   out_valid  out  1         packed word valid
//   out_data   out  DW*RATIO  packed word, lane k = out_data[k*DW +: DW]
//   out_keep   out  RATIO     per-lane valid flags
//   out_last   out  1         word was closed by in_last
//   out_ready  in   1         word accepted when out_valid && out_ready
// ---------------------------------------------------------------------------
module armleo_stream_packer #(
   parameter int DW    = 8,
   parameter int RATIO = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [DW-1:0]       in_data,
   input  logic                in_last,
   output logic                in_ready,
   output logic                out_valid,
   output logic [DW*RATIO-1:0] out_data,
   output logic [RATIO-1:0]    out_keep,
   output logic                out_last,
   input  logic                out_ready
);

   localparam int            CW        = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int            WW        = DW * RATIO;
   localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

   // Accumulator for the word being assembled and the next free lane.
   logic [WW-1:0]    acc_data;
   logic [RATIO-1:0] acc_keep;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             closing;
   logic [WW-1:0]    merged_data;
   logic [RATIO-1:0] merged_keep;

   // The output register can take a new word when it is empty or is being
   // drained this very cycle; that is what gives full throughput.
   assign in_ready = rst_n && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // A beat closes the word when it fills the top lane or ends the packet.
   assign closing  = (cnt == LAST_LANE) || in_last;

   // Accumulator with the incoming beat dropped into lane cnt. Lanes above
   // cnt are still zero because the accumulator is cleared on every close.
   always_comb begin
      // NOTE: every always_comb output gets a full default first, so a path
      // that skips an assignment cannot turn the signal into a latch.
      merged_data                = acc_data;
      merged_keep                = acc_keep;
      merged_data[cnt*DW +: DW]  = in_data;
      merged_keep[cnt]           = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every
      // right-hand side sees the pre-edge value, independent of statement
      // order inside this block.
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         acc_data  <= '0;
         acc_keep  <= '0;
         cnt       <= '0;
      end else begin
         // Word taken downstream; data/keep/last hold their last value.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (accept) begin
            if (closing) begin
               // Overrides the drain above when both happen together, so a
               // back-to-back word keeps out_valid high with no bubble.
               out_valid <= 1'b1;
               out_data  <= merged_data;
               out_keep  <= merged_keep;
               out_last  <= in_last;
               acc_data  <= '0;
               acc_keep  <= '0;
               cnt       <= '0;
            end else begin
               acc_data  <= merged_data;
               acc_keep  <= merged_keep;
               cnt       <= cnt + CW'(1);
            end
         end
      end
   end

endmodule
